sram1rw_param: RTL and testbench

- Parametrised single-port (1RW) synchronous SRAM behavioural model; next generation of the fixed-size SRAM1RW macro models.
- Adds configurable width/depth, per-granule write mask, selectable read latency and a reset-driven clear sweep with BUSY.
- Drop-in for cache tag/data arrays in the asap7 flow. Keeps the existing active-low control pins.

---
 rtl/sram1rw_param_if.sv | 20 ++
 rtl/sram1rw_param.sv | 123 ++++++++++++
 tb/tb_sram1rw_param.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sram1rw_param_if.sv
// Access bus of the parametrised 1RW SRAM model: address, controls, data, mask and status.
interface sram1rw_param_if #(
    parameter int unsigned WIDTH  = 46,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned MASK_W = 46
);
    logic [ADDR_W-1:0] A;
    logic              CSB;
    logic              WEB;
    logic              OEB;
    logic [WIDTH-1:0]  I;
    logic [MASK_W-1:0] WMASK;
    logic              PINJ;
    logic [WIDTH-1:0]  O;
    logic              BUSY;
    logic              PERR;

    modport master (output A, CSB, WEB, OEB, I, WMASK, PINJ, input O, BUSY, PERR);
    modport slave  (input A, CSB, WEB, OEB, I, WMASK, PINJ, output O, BUSY, PERR);
endinterface

// File: rtl/sram1rw_param.sv
// Parametrised single-port synchronous SRAM model with write mask, 1/2-cycle read latency
// and a reset-driven clear sweep. Define SRAM1RW_PARITY_EN to add per-word even parity.
module sram1rw_param #(
    parameter int unsigned      WIDTH     = 46,
    parameter int unsigned      DEPTH     = 128,
    parameter int unsigned      ADDR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned      MASK_GRAN = 1,
    parameter int unsigned      READ_LAT  = 1,
    parameter logic [WIDTH-1:0] INIT_VAL  = '0
) (
    input logic            CE,
    input logic            RST,
    sram1rw_param_if.slave bus
);
    localparam int unsigned MASK_W = WIDTH / MASK_GRAN;

    if (WIDTH % MASK_GRAN != 0) begin : g_bad_gran
        $error("sram1rw_param: WIDTH must be a multiple of MASK_GRAN");
    end
    if (READ_LAT != 1 && READ_LAT != 2) begin : g_bad_lat
        $error("sram1rw_param: READ_LAT must be 1 or 2");
    end

    typedef enum logic {S_CLEAR, S_READY} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic              busy;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [WIDTH-1:0]  s1_data;
    logic [WIDTH-1:0]  s2_data;

    logic              re_c;
    logic              we_c;
    logic              in_range_c;
    logic [WIDTH-1:0]  bit_mask_c;
    logic [WIDTH-1:0]  old_word_c;
    logic [WIDTH-1:0]  merged_c;

    assign re_c       = ~bus.CSB & ~bus.OEB;
    assign we_c       = ~bus.CSB & ~bus.WEB;
    assign in_range_c = (32'(bus.A) < DEPTH);

    // Expand the granule mask to bits and merge new data over the stored word
    always_comb begin
        bit_mask_c = '0;
        for (int unsigned k = 0; k < MASK_W; k++) begin
            bit_mask_c[k*MASK_GRAN +: MASK_GRAN] = {MASK_GRAN{bus.WMASK[k]}};
        end
        old_word_c = in_range_c ? mem[bus.A] : '0;
        merged_c   = (old_word_c & ~bit_mask_c) | (bus.I & bit_mask_c);
    end

    // Sweep/ready FSM, memory array and read pipeline; stage 2 always follows stage 1
    always_ff @(posedge CE) begin
        if (RST) begin
            state   <= S_CLEAR;
            cnt     <= '0;
            busy    <= 1'b1;
            s1_data <= '0;
            s2_data <= '0;
        end else begin
            s2_data <= s1_data;
            case (state)
                S_CLEAR: begin
                    mem[cnt] <= INIT_VAL;
                    cnt      <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end
                end
                S_READY: begin
                    // Read samples the pre-write word, giving read-before-write on collisions
                    if (re_c) begin
                        s1_data <= old_word_c;
                    end
                    if (we_c && in_range_c) begin
                        mem[bus.A] <= merged_c;
                    end
                end
            endcase
        end
    end

    assign bus.O    = (READ_LAT == 2) ? s2_data : s1_data;
    assign bus.BUSY = busy;

`ifdef SRAM1RW_PARITY_EN
    logic par_mem [DEPTH];
    logic p1;
    logic p2;
    logic perr_c;

    assign perr_c = in_range_c & ((^old_word_c) ^ par_mem[bus.A]);

    // Parity store and error pipeline, kept in step with the data path
    always_ff @(posedge CE) begin
        if (RST) begin
            p1 <= 1'b0;
            p2 <= 1'b0;
        end else begin
            p2 <= p1;
            if (state == S_CLEAR) begin
                par_mem[cnt] <= ^INIT_VAL;
            end else begin
                if (re_c) begin
                    p1 <= perr_c;
                end
                if (we_c && in_range_c) begin
                    par_mem[bus.A] <= (^merged_c) ^ bus.PINJ;
                end
            end
        end
    end

    assign bus.PERR = (READ_LAT == 2) ? p2 : p1;
`else
    logic unused_pinj;
    assign unused_pinj = bus.PINJ;
    assign bus.PERR    = 1'b0;
`endif
endmodule

// File: tb/tb_sram1rw_param.sv
// Bench for sram1rw_param: two instances (128x46 lat1, 100x46 gran2 lat2) against a behavioural model.
module tb_sram1rw_param;
    localparam int unsigned W  = 46;
    localparam int unsigned AW = 7;
    localparam logic [W-1:0] ONES   = '1;
    localparam logic [W-1:0] INIT_B = 46'h1234_5678_9ABC;
`ifdef SRAM1RW_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic          ce = 1'b0;
    logic          rst, csb, web, oeb, pinj;
    logic [AW-1:0] a;
    logic [W-1:0]  din, wmask;
    logic [22:0]   wm_b;

    always #5 ce = ~ce;

    sram1rw_param_if #(.WIDTH(W), .ADDR_W(AW), .MASK_W(46)) bus_a ();
    sram1rw_param_if #(.WIDTH(W), .ADDR_W(AW), .MASK_W(23)) bus_b ();

    always_comb begin
        for (int k = 0; k < 23; k++) wm_b[k] = wmask[2*k];
    end

    assign bus_a.A = a;    assign bus_a.CSB = csb;  assign bus_a.WEB = web;  assign bus_a.OEB = oeb;
    assign bus_a.I = din;  assign bus_a.WMASK = wmask; assign bus_a.PINJ = pinj;
    assign bus_b.A = a;    assign bus_b.CSB = csb;  assign bus_b.WEB = web;  assign bus_b.OEB = oeb;
    assign bus_b.I = din;  assign bus_b.WMASK = wm_b;  assign bus_b.PINJ = pinj;

    sram1rw_param #(.WIDTH(W), .DEPTH(128), .MASK_GRAN(1), .READ_LAT(1), .INIT_VAL(46'h0))
        dut_a (.CE(ce), .RST(rst), .bus(bus_a.slave));
    sram1rw_param #(.WIDTH(W), .DEPTH(100), .MASK_GRAN(2), .READ_LAT(2), .INIT_VAL(INIT_B))
        dut_b (.CE(ce), .RST(rst), .bus(bus_b.slave));

    // Reference model: index 0 models dut_a, index 1 models dut_b
    int unsigned  depth_m [2] = '{128, 100};
    int unsigned  gran_m  [2] = '{1, 2};
    int unsigned  lat_m   [2] = '{1, 2};
    logic [W-1:0] init_m  [2] = '{46'h0, INIT_B};
    logic [W-1:0] mm [2][128];
    logic         mp [2][128];
    bit           clr [2];
    int           cnt [2];
    logic [W-1:0] last_rd [2];
    logic         last_pe [2];
    logic [W-1:0] eo [2];
    logic         ep [2];

    int nvec = 0;
    int nerr = 0;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // O shows the most recent read result, delayed by one extra edge for latency 2
    task automatic model_edge();
        logic [W-1:0] bm, nw, prev_rd;
        logic         prev_pe;
        bit           re, we, inr;
        re = !csb && !oeb;
        we = !csb && !web;
        for (int d = 0; d < 2; d++) begin
            prev_rd = last_rd[d];
            prev_pe = last_pe[d];
            if (rst) begin
                clr[d] = 1'b1; cnt[d] = 0;
                last_rd[d] = '0; last_pe[d] = 1'b0; prev_rd = '0; prev_pe = 1'b0;
            end else if (clr[d]) begin
                mm[d][cnt[d]] = init_m[d];
                mp[d][cnt[d]] = ^init_m[d];
                cnt[d]++;
                if (cnt[d] == int'(depth_m[d])) clr[d] = 1'b0;
            end else begin
                inr = (32'(a) < depth_m[d]);
                if (re) begin
                    last_rd[d] = inr ? mm[d][a] : '0;
                    last_pe[d] = inr ? ((^mm[d][a]) ^ mp[d][a]) : 1'b0;
                end
                if (we && inr) begin
                    for (int j = 0; j < int'(W); j++) bm[j] = wmask[gran_m[d] * (j / gran_m[d])];
                    nw = (mm[d][a] & ~bm) | (din & bm);
                    mm[d][a] = nw;
                    mp[d][a] = (^nw) ^ pinj;
                end
            end
            eo[d] = (lat_m[d] == 2) ? prev_rd : last_rd[d];
            ep[d] = (lat_m[d] == 2) ? prev_pe : last_pe[d];
        end
    endtask

    task automatic tick();
        @(posedge ce);
        model_edge();
        @(negedge ce);
        check("o_a", bus_a.O, eo[0]);
        check("o_b", bus_b.O, eo[1]);
        check("busy_a", W'(bus_a.BUSY), W'(clr[0]));
        check("busy_b", W'(bus_b.BUSY), W'(clr[1]));
        check("perr_a", W'(bus_a.PERR), W'(PAR_EN & ep[0]));
        check("perr_b", W'(bus_b.PERR), W'(PAR_EN & ep[1]));
    endtask

    task automatic drive(bit r, bit cs, bit we_n, bit oe_n, logic [AW-1:0] ad,
                         logic [W-1:0] d, logic [W-1:0] m, bit pj);
        rst = r; csb = cs; web = we_n; oeb = oe_n; a = ad; din = d; wmask = m; pinj = pj;
    endtask

    task automatic idle();
        drive(1'b0, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0);
    endtask

    // Runs until both instances leave the sweep; returns edge counts to BUSY low
    task automatic sweep(output int n_a, output int n_b, input bit poke);
        n_a = 0; n_b = 0;
        for (int n = 1; n <= 300; n++) begin
            if (poke && n_b == 0) drive(1'b0, 1'b0, 1'b0, 1'b0, '0, ONES, ONES, 1'b1);
            else idle();
            tick();
            if (n_b == 0 && !bus_b.BUSY) n_b = n;
            if (!bus_a.BUSY) begin n_a = n; break; end
        end
    endtask

    typedef struct {
        bit            csb, web, oeb;
        logic [AW-1:0] a;
        logic [W-1:0]  d, m;
        bit            chk;
        logic [W-1:0]  exp_o;
    } vec_t;

    function automatic vec_t mk(bit cs, bit we_n, bit oe_n, logic [AW-1:0] ad,
                                logic [W-1:0] d, logic [W-1:0] m, bit chk, logic [W-1:0] e);
        vec_t v;
        v.csb = cs; v.web = we_n; v.oeb = oe_n; v.a = ad; v.d = d; v.m = m; v.chk = chk; v.exp_o = e;
        return v;
    endfunction

    initial begin
        vec_t         tbl [14];
        int           na, nb;
        logic [W-1:0] d7, d8;

        // Reset and full clear sweep
        drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0);
        tick();
        check("rst_o_a", bus_a.O, '0);
        check("rst_busy_a", W'(bus_a.BUSY), W'(1));
        check("rst_perr_a", W'(bus_a.PERR), '0);
        sweep(na, nb, 1'b0);
        check("busy_len_a", W'(na), W'(128));
        check("busy_len_b", W'(nb), W'(100));

        // Directed table; expected O is for dut_a (latency 1)
        tbl[0]  = mk(0, 1, 0, 7'd0,   '0,      '0,           1, '0);
        tbl[1]  = mk(0, 1, 0, 7'd64,  '0,      '0,           1, '0);
        tbl[2]  = mk(0, 1, 0, 7'd127, '0,      '0,           1, '0);
        tbl[3]  = mk(0, 0, 1, 7'd5,   ONES,    ONES,         1, '0);
        tbl[4]  = mk(0, 0, 1, 7'd5,   '0,      46'h3FF,      1, '0);
        tbl[5]  = mk(0, 1, 0, 7'd5,   '0,      '0,           1, 46'h3FFF_FFFF_FC00);
        tbl[6]  = mk(0, 0, 1, 7'd9,   46'h123, ONES,         1, 46'h3FFF_FFFF_FC00);
        tbl[7]  = mk(0, 0, 0, 7'd9,   46'h456, ONES,         1, 46'h123);
        tbl[8]  = mk(0, 1, 0, 7'd9,   '0,      '0,           1, 46'h456);
        tbl[9]  = mk(1, 1, 1, 7'd9,   '0,      '0,           1, 46'h456);
        tbl[10] = mk(0, 0, 1, 7'd9,   '0,      '0,           1, 46'h456);
        tbl[11] = mk(0, 1, 0, 7'd9,   '0,      '0,           1, 46'h456);
        tbl[12] = mk(0, 0, 1, 7'd120, ONES,    ONES,         1, 46'h456);
        tbl[13] = mk(0, 1, 0, 7'd120, '0,      '0,           1, ONES);
        for (int i = 0; i < 14; i++) begin
            drive(1'b0, tbl[i].csb, tbl[i].web, tbl[i].oeb, tbl[i].a, tbl[i].d, tbl[i].m, 1'b0);
            tick();
            if (tbl[i].chk) check($sformatf("tbl%0d", i), bus_a.O, tbl[i].exp_o);
        end

        // Latency-2 timing on dut_b; its last read (A=120) was out of range, so O_b is 0
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd3, 46'hAB, ONES, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd3, '0, '0, 1'b0);
        tick();
        check("lat_b_edge_n", bus_b.O, '0);
        check("lat_a_edge_n", bus_a.O, 46'hAB);
        for (int k = 0; k < 3; k++) begin
            idle();
            tick();
            check($sformatf("lat_b_hold%0d", k), bus_b.O, 46'hAB);
        end

        // Parity inject on A=7, clean word on A=8
        d7 = W'({$urandom, $urandom});
        d8 = W'({$urandom, $urandom});
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd7, d7, ONES, 1'b1);
        tick();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 7'd8, d8, ONES, 1'b0);
        tick();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd7, '0, '0, 1'b0);
        tick();
        check("par_o_a", bus_a.O, d7);
        check("par_perr_a7", W'(bus_a.PERR), W'(PAR_EN));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd8, '0, '0, 1'b0);
        tick();
        check("par_perr_a8", W'(bus_a.PERR), '0);
        check("par_o_b", bus_b.O, d7);
        check("par_perr_b7", W'(bus_b.PERR), W'(PAR_EN));
        idle();
        tick();
        check("par_perr_b8", W'(bus_b.PERR), '0);

        // Reset 50 edges into a sweep, then requests during BUSY must be ignored
        drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0);
        tick();
        for (int k = 0; k < 50; k++) begin idle(); tick(); end
        drive(1'b1, 1'b1, 1'b1, 1'b1, '0, '0, '0, 1'b0);
        tick();
        sweep(na, nb, 1'b1);
        check("resweep_len_a", W'(na), W'(128));
        check("resweep_len_b", W'(nb), W'(100));
        drive(1'b0, 1'b0, 1'b1, 1'b0, 7'd0, '0, '0, 1'b0);
        tick();
        check("resweep_rd_a", bus_a.O, '0);
        idle();
        tick();
        check("resweep_rd_b", bus_b.O, INIT_B);

        // Randomised traffic with occasional resets
        for (int k = 0; k < 2000; k++) begin
            drive(($urandom % 400) == 0, ($urandom % 10) < 3, 1'($urandom), 1'($urandom),
                  AW'($urandom), W'({$urandom, $urandom}),
                  (($urandom % 4) == 0) ? ONES : W'({$urandom, $urandom}), ($urandom % 8) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
